data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/data_mem_unit.sv | 178 +++++++++++++++++
 tb/tb_data_mem_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory unit: access sizes and FSM states.
// Imported by data_mem_unit and dmem_ram.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    return (size == SZ_BAD)
        || (size == SZ_HALF && lane[0])
        || (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage with byte-enable write and a registered read port.
// Reads return the word as it stood before a same-cycle write.
module dmem_ram
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte/half/word data memory with one-cycle response latency.
// Define DMEM_INIT_CLEAR_EN to zero the array after reset.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          err;
  logic          ready;
  logic          sweep;
  logic          accept;
  logic [AW-1:0] clr_idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          valid_q;
  logic          err_q;
  logic          load_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          uns_q;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   rdata;

  // Upper address bits are ignored so the map wraps.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  assign lane   = req_addr[1:0];
  assign idx    = req_addr[AW+1:2];
  assign err    = misaligned(req_size, lane);
  assign accept = req_valid & ready & ~reset;

`ifdef DMEM_INIT_CLEAR_EN
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (state == ST_INIT) cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT: if (cnt == AW'(DEPTH - 1)) state_nx = ST_IDLE;
      ST_IDLE: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    sweep = 1'b0;
    unique case (state)
      ST_INIT: begin
        busy  = 1'b1;
        sweep = 1'b1;
      end
      ST_IDLE: ready = 1'b1;
    endcase
  end

  assign clr_idx = cnt;
`else
  assign ready   = 1'b1;
  assign busy    = 1'b0;
  assign sweep   = 1'b0;
  assign clr_idx = '0;
`endif

  assign req_ready = ready;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    unique case (1'b1)
      req_size == SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      req_size == SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      req_size == SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign ram_we    = sweep ? ~reset : (accept & req_we & ~err);
  assign ram_be    = sweep ? 4'b1111 : be;
  assign ram_addr  = sweep ? clr_idx : idx;
  assign ram_wdata = sweep ? 32'h0 : wdata_rep;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= accept;
      err_q   <= accept & err;
      load_q  <= accept & ~req_we & ~err;
    end
  end

  always_ff @(posedge clk) begin
    size_q <= req_size;
    lane_q <= lane;
    uns_q  <= req_unsigned;
  end

  // Stores and errors answer with zero data.
  always_comb begin
    byte_v = ram_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    rdata  = 32'h0;
    if (load_q) begin
      unique case (1'b1)
        size_q == SZ_BYTE: rdata = {{24{~uns_q & byte_v[7]}}, byte_v};
        size_q == SZ_HALF: rdata = {{16{~uns_q & half_v[15]}}, half_v};
        size_q == SZ_WORD: rdata = ram_rdata;
        default:           rdata = 32'h0;
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata;

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a byte-array model.
// Follows the DMEM_INIT_CLEAR_EN setting of the build.
module tb_data_mem_unit;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int MB    = 4 * DEPTH;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int SWEEP = DEPTH;
`else
  localparam int SWEEP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  data_mem_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  mm [MB];
  bit          kn [MB];
  int          left = 0;
  bit          pend_v = 0;
  bit          pend_err = 0;
  bit          pend_chk = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_rsp = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic observe();
    chk("busy", {31'b0, busy}, {31'b0, left > 0});
    chk("ready", {31'b0, req_ready}, {31'b0, left == 0});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, pend_v});
    if (pend_v) begin
      last_rsp = rsp_rdata;
      last_err = rsp_err;
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, pend_err});
      if (pend_chk) chk("rsp_rdata", rsp_rdata, pend_data);
    end
  endtask

  task automatic model(input logic v, input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] wd);
    int          i;
    int          n;
    logic [31:0] val;
    if (left > 0) begin
      left--;
      if (left == 0) begin
        for (int k = 0; k < MB; k++) begin
          mm[k] = 8'h00;
          kn[k] = 1'b1;
        end
      end
      pend_v = 0;
      return;
    end
    pend_v = v;
    if (!v) return;
    i = int'(a % 32'(MB));
    n = 1 << sz;
    pend_err  = (sz == 2'b11) || ((a % 32'(n)) != 0);
    pend_data = 32'h0;
    pend_chk  = 1;
    if (pend_err) return;
    if (we) begin
      for (int k = 0; k < n; k++) begin
        mm[i+k] = wd[8*k +: 8];
        kn[i+k] = 1'b1;
      end
    end else begin
      val = 32'h0;
      for (int k = 0; k < n; k++) begin
        val = val | (32'(mm[i+k]) << (8 * k));
        if (!kn[i+k]) pend_chk = 0;
      end
      if (!un && n == 1 && val[7])  val = val | 32'hFFFFFF00;
      if (!un && n == 2 && val[15]) val = val | 32'hFFFF0000;
      pend_data = val;
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] wd);
    observe();
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    model(v, we, sz, un, a, wd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input logic v, input logic [31:0] a,
                          input logic [31:0] wd);
    reset     = 1'b1;
    req_valid = v;
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    pend_v = 0;
    left   = SWEEP;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 4 * DEPTH) begin
      step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int k = 0; k < MB; k++) kn[k] = 1'b0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    do_reset(1'b0, 32'h0, 32'h0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    sweep_len(n);
    chk("sweep_len", n, SWEEP);

    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
    idle();
`ifdef DMEM_INIT_CLEAR_EN
    chk("ld_3fc", last_rsp, 32'h0);
`endif

    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8899AABB);
    step(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0);
    idle();
    chk("lb_s", last_rsp, 32'hFFFFFF99);
    step(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0);
    idle();
    chk("lb_u", last_rsp, 32'h00000099);
    step(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
    idle();
    chk("lh_s", last_rsp, 32'hFFFF8899);

    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
    step(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000005A);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    idle();
    chk("sb_merge", last_rsp, 32'h11225A44);

    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h04, 32'hCAFEF00D);
    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h0BADBAD0);
    idle();
    chk("err_mis", {31'b0, last_err}, 32'h1);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0);
    idle();
    chk("err_nowr", last_rsp, 32'hCAFEF00D);
    step(1'b1, 1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
    idle();
    chk("err_sz3", {31'b0, last_err}, 32'h1);

    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    chk("b2b_v", {31'b0, rsp_valid}, 32'h1);
    idle();
    chk("b2b_rd", last_rsp, 32'hDEADBEEF);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h440, 32'h0);
    idle();
    chk("alias", last_rsp, 32'hDEADBEEF);

    repeat (600) begin
      n  = $urandom_range(0, 15);
      sz = (n == 15) ? 2'b11 : 2'(n % 3);
      a  = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 7)) << 10);
      step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();

    step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h80, 32'hA5A5A5A5);
    do_reset(1'b1, 32'h80, 32'hFFFFFFFF);
    chk("rst_drop", {31'b0, rsp_valid}, 32'h0);
    sweep_len(n);
    chk("sweep_txn", n, SWEEP);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0);
    idle();

    do_reset(1'b0, 32'h0, 32'h0);
    repeat (SWEEP > 100 ? 100 : 0) idle();
    do_reset(1'b1, 32'h0, 32'h12345678);
    sweep_len(n);
    chk("sweep_re", n, SWEEP);
    step(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
